bitstream_self_writer: RTL and testbench

Upstream configuration feeder for eFPGA_top. It streams a bitstream byte image from a synchronous byte ROM and packs each group of 4 bytes into a big-endian 32-bit word. Each word is driven onto the fabric's SelfWriteData/SelfWriteStrobe port with fixed setup and hold spacing. Replaces the bench-side loading loop, so demo designs can self-configure on silicon and in emulation.

---
 rtl/bitstream_self_writer.sv | 245 ++++++++++++++++++++++++
 tb/tb_bitstream_self_writer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/bitstream_self_writer.sv
// bitstream_self_writer: streams a bitstream byte image out of a synchronous
// byte ROM. It packs each group of 4 bytes big-endian into a 32-bit word and
// presents the word on SelfWriteData. SelfWriteStrobe is pulsed for one cycle
// with PRE_STROBE cycles of setup before it and POST_STROBE cycles of hold after.
// Optional feature: define BITSTREAM_CHECKSUM_EN to add a 32-bit running sum of
// the strobed words on the checksum port.
`timescale 1ns/1ps

module bitstream_self_writer #(
  parameter int ADDR_W      = 14,
  parameter int START_DELAY = 20,
  parameter int PRE_STROBE  = 2,
  parameter int POST_STROBE = 2
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   len_bytes,
  output logic              rom_rd_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [7:0]        rom_data,
  output logic [31:0]       SelfWriteData,
  output logic              SelfWriteStrobe,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-2:0] words_written
`ifdef BITSTREAM_CHECKSUM_EN
  ,
  output logic [31:0]       checksum
`endif
);

  localparam int CNT_W = 16;
  localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE, S_DELAY, S_FETCH, S_SETUP, S_STROBE, S_GAP, S_DONE
  } state_t;

  // Images longer than the ROM address space are truncated to the full ROM.
  function automatic logic [ADDR_W:0] clamp_len(input logic [ADDR_W:0] len);
    if (len > MAX_LEN) begin
      return MAX_LEN;
    end else begin
      return len;
    end
  endfunction

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W:0]     base_q, base_d;
  logic [ADDR_W:0]     len_q, len_d;
  logic [31:0]         word_q, word_d;
  logic [31:0]         data_q, data_d;
  logic                strobe_q, strobe_d;
  logic                rd_en_q, rd_en_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [ADDR_W-2:0]   wcnt_q, wcnt_d;

  logic                accept_s;
  logic [ADDR_W:0]     len_in_s;
  logic [1:0]          fetch_idx_s;
  logic [ADDR_W:0]     byte_addr_s;
  logic [7:0]          byte_s;
  logic                last_word_s;
  state_t              gap_state_s;
  logic [ADDR_W:0]     gap_base_s;
  logic [ADDR_W:0]     rd_addr_s;

  assign accept_s    = start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign len_in_s    = clamp_len(len_bytes);
  // In FETCH, cnt_q = 1..4 means the byte read on the previous cycle is on rom_data.
  assign fetch_idx_s = cnt_q[1:0] - 2'd1;
  assign byte_addr_s = base_q + {{(ADDR_W-1){1'b0}}, fetch_idx_s};
  assign byte_s      = (byte_addr_s < len_q) ? rom_data : 8'h00;
  assign last_word_s = (base_q + {{(ADDR_W-2){1'b0}}, 3'd4}) >= len_q;
  assign gap_state_s = last_word_s ? S_DONE : S_FETCH;
  assign gap_base_s  = last_word_s ? base_q : (base_q + {{(ADDR_W-2){1'b0}}, 3'd4});

  // Sequencer next-state, byte packing and word-count logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    base_d  = base_q;
    len_d   = len_q;
    word_d  = word_q;
    data_d  = data_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept_s) begin
          len_d  = len_in_s;
          base_d = {(ADDR_W+1){1'b0}};
          cnt_d  = {CNT_W{1'b0}};
          wcnt_d = {(ADDR_W-1){1'b0}};
          if (len_in_s == {(ADDR_W+1){1'b0}}) begin
            state_d = S_DONE;
          end else if (START_DELAY == 0) begin
            state_d = S_FETCH;
          end else begin
            state_d = S_DELAY;
          end
        end else begin
          state_d = state_q;
        end
      end
      S_DELAY: begin
        if (cnt_q == CNT_W'(START_DELAY - 1)) begin
          state_d = S_FETCH;
          cnt_d   = {CNT_W{1'b0}};
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_FETCH: begin
        if (cnt_q != {CNT_W{1'b0}}) begin
          word_d = {word_q[23:0], byte_s};
        end else begin
          word_d = word_q;
        end
        if (cnt_q == CNT_W'(4)) begin
          data_d  = {word_q[23:0], byte_s};
          cnt_d   = {CNT_W{1'b0}};
          state_d = S_SETUP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_SETUP: begin
        if (cnt_q == CNT_W'(PRE_STROBE - 1)) begin
          state_d = S_STROBE;
          cnt_d   = {CNT_W{1'b0}};
          wcnt_d  = wcnt_q + (ADDR_W-1)'(1);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_STROBE: begin
        cnt_d = {CNT_W{1'b0}};
        if (POST_STROBE == 0) begin
          state_d = gap_state_s;
          base_d  = gap_base_s;
        end else begin
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        if (cnt_q == CNT_W'(POST_STROBE - 1)) begin
          state_d = gap_state_s;
          base_d  = gap_base_s;
          cnt_d   = {CNT_W{1'b0}};
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = {CNT_W{1'b0}};
      end
    endcase
  end

  // Output decode from the next state so every port comes straight off a flop.
  always_comb begin
    rd_addr_s = base_d + {{(ADDR_W-1){1'b0}}, cnt_d[1:0]};
    rd_en_d   = (state_d == S_FETCH) && (cnt_d < CNT_W'(4)) && (rd_addr_s < len_d);
    if (rd_en_d) begin
      addr_d = rd_addr_s[ADDR_W-1:0];
    end else begin
      addr_d = addr_q;
    end
    strobe_d = (state_d == S_STROBE);
    busy_d   = (state_d == S_DELAY) || (state_d == S_FETCH) || (state_d == S_SETUP) ||
               (state_d == S_STROBE) || (state_d == S_GAP);
    done_d   = (state_d == S_DONE);
  end

  // State and output registers; reset drops every output to 0 immediately.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= {CNT_W{1'b0}};
      base_q   <= {(ADDR_W+1){1'b0}};
      len_q    <= {(ADDR_W+1){1'b0}};
      word_q   <= 32'h0000_0000;
      data_q   <= 32'h0000_0000;
      strobe_q <= 1'b0;
      rd_en_q  <= 1'b0;
      addr_q   <= {ADDR_W{1'b0}};
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      wcnt_q   <= {(ADDR_W-1){1'b0}};
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      base_q   <= base_d;
      len_q    <= len_d;
      word_q   <= word_d;
      data_q   <= data_d;
      strobe_q <= strobe_d;
      rd_en_q  <= rd_en_d;
      addr_q   <= addr_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      wcnt_q   <= wcnt_d;
    end
  end

  assign rom_rd_en       = rd_en_q;
  assign rom_addr        = addr_q;
  assign SelfWriteData   = data_q;
  assign SelfWriteStrobe = strobe_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign words_written   = wcnt_q;

`ifdef BITSTREAM_CHECKSUM_EN
  logic [31:0] checksum_q, checksum_d;

  // Running sum of strobed words, taken the cycle after each strobe.
  always_comb begin
    if (accept_s) begin
      checksum_d = 32'h0000_0000;
    end else if (strobe_q) begin
      checksum_d = checksum_q + data_q;
    end else begin
      checksum_d = checksum_q;
    end
  end

  // Checksum register.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      checksum_q <= 32'h0000_0000;
    end else begin
      checksum_q <= checksum_d;
    end
  end

  assign checksum = checksum_q;
`endif

endmodule

// File: tb/tb_bitstream_self_writer.sv
// Directed bench for bitstream_self_writer with a behavioural 1-cycle ROM.
`timescale 1ns/1ps

module tb_bitstream_self_writer;

  logic        CLK;
  logic        reset;
  logic        start;
  logic [14:0] len_bytes;
  logic        rom_rd_en;
  logic [13:0] rom_addr;
  logic [7:0]  rom_data;
  logic [31:0] SelfWriteData;
  logic        SelfWriteStrobe;
  logic        busy;
  logic        done;
  logic [12:0] words_written;
`ifdef BITSTREAM_CHECKSUM_EN
  logic [31:0] checksum;
`endif

  bitstream_self_writer dut (
    .CLK(CLK), .reset(reset), .start(start), .len_bytes(len_bytes),
    .rom_rd_en(rom_rd_en), .rom_addr(rom_addr), .rom_data(rom_data),
    .SelfWriteData(SelfWriteData), .SelfWriteStrobe(SelfWriteStrobe),
    .busy(busy), .done(done), .words_written(words_written)
`ifdef BITSTREAM_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  logic [7:0]  mem [0:255];
  int          cyc;
  int          n_cmp;
  int          n_fail;
  int          n_strb;
  int          n_rd;
  int          n_busy;
  logic [31:0] strb_data [0:63];
  int          strb_cyc  [0:63];
  logic [13:0] rd_addr_log [0:255];
  int          rd_cyc      [0:255];

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  always @(posedge CLK) begin
    if (rom_rd_en) rom_data <= mem[rom_addr[7:0]];
  end

  always @(negedge CLK) begin
    if (SelfWriteStrobe) begin
      if (n_strb < 64) begin
        strb_data[n_strb] = SelfWriteData;
        strb_cyc[n_strb]  = cyc;
      end
      n_strb = n_strb + 1;
    end
    if (rom_rd_en) begin
      if (n_rd < 256) begin
        rd_addr_log[n_rd] = rom_addr;
        rd_cyc[n_rd]      = cyc;
      end
      n_rd = n_rd + 1;
    end
    if (busy) n_busy = n_busy + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp = n_cmp + 1;
    assert (obs === exp) else begin
      n_fail = n_fail + 1;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input string tag, input int max_cyc);
    int k;
    k = 0;
    while (done !== 1'b1 && k < max_cyc) begin
      @(posedge CLK); #1;
      k++;
    end
    chk(tag, {63'd0, done}, 64'd1);
  endtask

  int acc, s0, r0, b0, hi;

  // Pulse start for one cycle; acc = cycle count just after the accepting edge.
  task automatic go(input logic [14:0] len);
    len_bytes = len;
    start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    acc = cyc;
  endtask

  initial begin
    n_cmp = 0; n_fail = 0;
    reset = 1'b1; start = 1'b0; len_bytes = 15'd0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    repeat (2) @(posedge CLK); #1;
    // Reset state
    chk("rst_rd_en",  {63'd0, rom_rd_en}, 64'd0);
    chk("rst_addr",   {50'd0, rom_addr}, 64'd0);
    chk("rst_data",   {32'd0, SelfWriteData}, 64'd0);
    chk("rst_strobe", {63'd0, SelfWriteStrobe}, 64'd0);
    chk("rst_busy",   {63'd0, busy}, 64'd0);
    chk("rst_done",   {63'd0, done}, 64'd0);
    chk("rst_words",  {51'd0, words_written}, 64'd0);
    reset = 1'b0;
    @(posedge CLK); #1;

    // Test 1: 8 bytes, two full words
    for (int i = 0; i < 8; i++) mem[i] = 8'(i + 1);
    s0 = n_strb; r0 = n_rd;
    go(15'd8);
    chk("t1_busy", {63'd0, busy}, 64'd1);
    wait_done("t1_done", 200);
    chk("t1_nstrb", 64'(n_strb - s0), 64'd2);
    chk("t1_w0", {32'd0, strb_data[s0]}, 64'h0102_0304);
    chk("t1_w1", {32'd0, strb_data[s0+1]}, 64'h0506_0708);
    chk("t1_period", 64'(strb_cyc[s0+1] - strb_cyc[s0]), 64'd10);
    chk("t1_first_rd", 64'(rd_cyc[r0] - acc), 64'd20);
    chk("t1_first_strb", 64'(strb_cyc[s0] - acc), 64'd27);
    chk("t1_nrd", 64'(n_rd - r0), 64'd8);
    chk("t1_words", {51'd0, words_written}, 64'd2);
    chk("t1_busy_end", {63'd0, busy}, 64'd0);
    chk("t1_hold", {32'd0, SelfWriteData}, 64'h0506_0708);

    // Test 2: 6 bytes, padded last word, with an ignored start pulse mid-load
    mem[0] = 8'hAA; mem[1] = 8'hBB; mem[2] = 8'hCC;
    mem[3] = 8'hDD; mem[4] = 8'hEE; mem[5] = 8'hFF;
    mem[6] = 8'h11; mem[7] = 8'h22;
    s0 = n_strb; r0 = n_rd;
    go(15'd6);
    chk("t2_done_clr", {63'd0, done}, 64'd0);
    chk("t2_words_clr", {51'd0, words_written}, 64'd0);
    repeat (15) @(posedge CLK); #1;
    start = 1'b1; len_bytes = 15'd2;
    @(posedge CLK); #1;
    start = 1'b0; len_bytes = 15'd6;
    wait_done("t2_done", 200);
    chk("t2_nstrb", 64'(n_strb - s0), 64'd2);
    chk("t2_w0", {32'd0, strb_data[s0]}, 64'hAABB_CCDD);
    chk("t2_w1", {32'd0, strb_data[s0+1]}, 64'hEEFF_0000);
    chk("t2_nrd", 64'(n_rd - r0), 64'd6);
    hi = 0;
    for (int i = r0; i < n_rd && i < 256; i++) if (rd_addr_log[i] >= 14'd6) hi++;
    chk("t2_no_pad_reads", 64'(hi), 64'd0);

    // Test 3: zero-length image
    s0 = n_strb; r0 = n_rd; b0 = n_busy;
    go(15'd0);
    chk("t3_done", {63'd0, done}, 64'd1);
    chk("t3_words_clr", {51'd0, words_written}, 64'd0);
    repeat (10) @(posedge CLK); #1;
    chk("t3_nrd", 64'(n_rd - r0), 64'd0);
    chk("t3_nstrb", 64'(n_strb - s0), 64'd0);
    chk("t3_nbusy", 64'(n_busy - b0), 64'd0);

    // Test 4: start held high; second load only after done
    for (int i = 0; i < 8; i++) mem[i] = 8'(i + 1);
    s0 = n_strb;
    len_bytes = 15'd8; start = 1'b1;
    @(posedge CLK); #1;
    chk("t4_busy", {63'd0, busy}, 64'd1);
    repeat (10) @(posedge CLK); #1;
    len_bytes = 15'd4;
    wait_done("t4_done1", 200);
    chk("t4_nstrb1", 64'(n_strb - s0), 64'd2);
    chk("t4_w1", {32'd0, strb_data[s0+1]}, 64'h0506_0708);
    @(posedge CLK); #1;
    start = 1'b0;
    chk("t4_relaunch_done", {63'd0, done}, 64'd0);
    chk("t4_relaunch_busy", {63'd0, busy}, 64'd1);
    wait_done("t4_done2", 200);
    chk("t4_nstrb2", 64'(n_strb - s0), 64'd3);
    chk("t4_w2", {32'd0, strb_data[s0+2]}, 64'h0102_0304);

    // Test 5: reset during SETUP of word 3, then reload 4 bytes
    for (int i = 0; i < 16; i++) mem[i] = 8'(8'h10 + i);
    s0 = n_strb;
    go(15'd16);
    do begin @(posedge CLK); #1; end while (cyc < acc + 45);
    chk("t5_setup_data", {32'd0, SelfWriteData}, 64'h1819_1A1B);
    chk("t5_setup_words", {51'd0, words_written}, 64'd2);
    chk("t5_setup_strobe", {63'd0, SelfWriteStrobe}, 64'd0);
    reset = 1'b1;
    #1;
    chk("t5_rst_data", {32'd0, SelfWriteData}, 64'd0);
    chk("t5_rst_busy", {63'd0, busy}, 64'd0);
    chk("t5_rst_words", {51'd0, words_written}, 64'd0);
    chk("t5_rst_rd", {63'd0, rom_rd_en}, 64'd0);
    chk("t5_rst_done", {63'd0, done}, 64'd0);
    repeat (2) @(posedge CLK); #1;
    reset = 1'b0;
    chk("t5_nstrb_cut", 64'(n_strb - s0), 64'd2);
    s0 = n_strb; r0 = n_rd;
    go(15'd4);
    wait_done("t5_done", 200);
    chk("t5_nstrb", 64'(n_strb - s0), 64'd1);
    chk("t5_w0", {32'd0, strb_data[s0]}, 64'h1011_1213);
    chk("t5_first_addr", {50'd0, rd_addr_log[r0]}, 64'd0);
    chk("t5_words", {51'd0, words_written}, 64'd1);

`ifdef BITSTREAM_CHECKSUM_EN
    // Test 6: checksum wraps modulo 2**32
    mem[0] = 8'hFF; mem[1] = 8'hFF; mem[2] = 8'hFF; mem[3] = 8'hFF;
    mem[4] = 8'h00; mem[5] = 8'h00; mem[6] = 8'h00; mem[7] = 8'h02;
    go(15'd8);
    wait_done("t6_done", 200);
    chk("t6_checksum", {32'd0, checksum}, 64'h0000_0001);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
